// File: rtl/matriz_pkg.sv
// Shared definitions for the matrix controller: default dimensions,
// opcode encoding and the controller state enumeration.
package matriz_pkg;

   localparam int N = 5;
   localparam int W = 8;

   localparam logic [2:0] SOMA       = 3'b000;
   localparam logic [2:0] SUB        = 3'b001;
   localparam logic [2:0] OPOSTA     = 3'b010;
   localparam logic [2:0] TRANSPOSTA = 3'b011;
   localparam logic [2:0] ESCALAR    = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } estado_t;

endpackage

// File: rtl/elemento_ula.sv
// Combinational per-element ALU: computes one matrix element at double width,
// truncates to W bits and flags wrap-around or an unsupported opcode.
module elemento_ula #(
   parameter int W = matriz_pkg::W
) (
   input  logic [2:0]          opcode,
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   input  logic signed [W-1:0] escalar,
   output logic signed [W-1:0] resultado,
   output logic                ovf,
   output logic                invalido
);
   import matriz_pkg::*;

   logic signed [2*W-1:0] ax, bx, ex, completo;

   assign ax = {{W{a[W-1]}}, a};
   assign bx = {{W{b[W-1]}}, b};
   assign ex = {{W{escalar[W-1]}}, escalar};

   always_comb begin
      completo = '0;
      invalido = 1'b0;
      case (opcode)
         SOMA:       completo = ax + bx;
         SUB:        completo = ax - bx;
         OPOSTA:     completo = -ax;
         TRANSPOSTA: completo = ax;
         ESCALAR:    completo = ex * ax;
         default:    invalido = 1'b1;
      endcase
   end

   assign resultado = completo[W-1:0];
   // the value fits in W bits only if every bit above the sign bit matches it
   assign ovf = (completo[2*W-1:W-1] != {(W+1){completo[W-1]}});

endmodule

// File: rtl/controle_matriz.sv
// Sequential N x N matrix operation controller: one element per cycle through
// a shared element ALU.
//   state | meaning
//   IDLE  | waiting for start; results and flags held
//   EXEC  | computing element idx, one per cycle
//   DONE  | one-cycle done pulse, then back to IDLE
module controle_matriz #(
   parameter int N = matriz_pkg::N,
   parameter int W = matriz_pkg::W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [2:0]          opcode,
   input  logic signed [W-1:0] escalar,
   input  logic [N*N*W-1:0]    matriz_A,
   input  logic [N*N*W-1:0]    matriz_B,
   output logic [N*N*W-1:0]    m_resultado,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic                erro
);
   import matriz_pkg::*;

   localparam int NN = N * N;
   localparam int IW = (NN > 1) ? $clog2(NN) : 1;
   localparam logic [IW-1:0] ULTIMO = IW'(NN - 1);
   localparam logic [IW-1:0] UM     = IW'(1);

   estado_t             estado;
   logic [IW-1:0]       idx;
   logic [2:0]          op_r;
   logic signed [W-1:0] esc_r;
   logic [N*N*W-1:0]    a_r, b_r;

   int                  linha, coluna, fonte;
   logic signed [W-1:0] op_a, op_b, res;
   logic                ovf, inv;

   // transpose reads A at (col,row) for destination (row,col)
   always_comb begin
      linha  = int'(idx) / N;
      coluna = int'(idx) % N;
      fonte  = (op_r == TRANSPOSTA) ? (coluna * N + linha) : int'(idx);
      op_a   = a_r[fonte*W +: W];
      op_b   = b_r[int'(idx)*W +: W];
   end

   elemento_ula #(.W(W)) u_ula (
      .opcode    (op_r),
      .a         (op_a),
      .b         (op_b),
      .escalar   (esc_r),
      .resultado (res),
      .ovf       (ovf),
      .invalido  (inv)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado      <= IDLE;
         idx         <= '0;
         op_r        <= '0;
         esc_r       <= '0;
         a_r         <= '0;
         b_r         <= '0;
         m_resultado <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overflow    <= 1'b0;
         erro        <= 1'b0;
      end else begin
         case (estado)
            IDLE: begin
               if (start) begin
                  op_r     <= opcode;
                  esc_r    <= escalar;
                  a_r      <= matriz_A;
                  b_r      <= matriz_B;
                  overflow <= 1'b0;
                  erro     <= 1'b0;
                  idx      <= '0;
                  busy     <= 1'b1;
                  estado   <= EXEC;
               end
            end
            EXEC: begin
               m_resultado[int'(idx)*W +: W] <= res;
               overflow <= overflow | ovf;
               erro     <= erro | inv;
               if (idx == ULTIMO) begin
                  idx    <= '0;
                  done   <= 1'b1;
                  estado <= DONE;
               end else begin
                  idx <= idx + UM;
               end
            end
            DONE: begin
               done   <= 1'b0;
               busy   <= 1'b0;
               estado <= IDLE;
            end
            default: begin
               done   <= 1'b0;
               busy   <= 1'b0;
               estado <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_controle_matriz.sv
// Scoreboard bench for controle_matriz: driver pushes model results, a monitor
// pops and compares them on every done pulse.
module tb_controle_matriz;

   localparam int N   = 5;
   localparam int W   = 8;
   localparam int NN  = N * N;
   localparam int NNW = NN * W;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                start = 1'b0;
   logic [2:0]          opcode = '0;
   logic signed [W-1:0] escalar = '0;
   logic [NNW-1:0]      matriz_A = '0;
   logic [NNW-1:0]      matriz_B = '0;
   logic [NNW-1:0]      m_resultado;
   logic                busy, done, overflow, erro;

   controle_matriz #(.N(N), .W(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .opcode      (opcode),
      .escalar     (escalar),
      .matriz_A    (matriz_A),
      .matriz_B    (matriz_B),
      .m_resultado (m_resultado),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .erro        (erro)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NNW-1:0] res;
      logic           ovf;
      logic           err;
   } esperado_t;

   esperado_t      fila[$];
   int             checks = 0;
   int             failures = 0;
   logic [NNW-1:0] ult_res = '0;
   logic           ult_ovf = 1'b0;
   logic           ult_err = 1'b0;
   bit             mon_on = 1'b0;

   task automatic verifica(input string nome, input logic [NNW-1:0] atual,
                           input logic [NNW-1:0] esp);
      checks++;
      if (atual !== esp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nome, atual, esp);
      end
   endtask

   // Reference: plain integer arithmetic on each element, then wrap to W bits.
   function automatic esperado_t modelo(input logic [2:0] op, input logic [W-1:0] esc,
                                        input logic [NNW-1:0] a, input logic [NNW-1:0] b);
      esperado_t      e;
      int             av, bv, at, full, r, c;
      logic [W-1:0]   t;
      e.res = '0;
      e.ovf = 1'b0;
      e.err = (op > 3'd4);
      for (int j = 0; j < NN; j++) begin
         r  = j / N;
         c  = j % N;
         av = int'($signed(a[j*W +: W]));
         bv = int'($signed(b[j*W +: W]));
         at = int'($signed(a[(c*N + r)*W +: W]));
         case (op)
            3'd0:    full = av + bv;
            3'd1:    full = av - bv;
            3'd2:    full = -av;
            3'd3:    full = at;
            3'd4:    full = int'($signed(esc)) * av;
            default: full = 0;
         endcase
         t = full[W-1:0];
         e.res[j*W +: W] = t;
         if (full > (2**(W-1)) - 1 || full < -(2**(W-1))) e.ovf = 1'b1;
      end
      return e;
   endfunction

   function automatic logic [NNW-1:0] vet_rand();
      logic [NNW-1:0] v;
      logic [W-1:0]   t;
      for (int j = 0; j < NN; j++) begin
         t = W'($urandom);
         v[j*W +: W] = t;
      end
      return v;
   endfunction

   // Call right after a negedge; the following posedge accepts the request.
   task automatic lancar(input logic [2:0] op, input logic [W-1:0] esc,
                         input logic [NNW-1:0] a, input logic [NNW-1:0] b);
      opcode   = op;
      escalar  = esc;
      matriz_A = a;
      matriz_B = b;
      start    = 1'b1;
      fila.push_back(modelo(op, esc, a, b));
      @(negedge clk);
      start = 1'b0;
   endtask

   // Scramble inputs and pulse start while busy; optional forced re-pulse with SOMA.
   task automatic aguardar(input int repulso);
      for (int c = 1; c <= NN + 10; c++) begin
         if (done) begin
            start = 1'b0;
            return;
         end
         matriz_A = vet_rand();
         matriz_B = vet_rand();
         escalar  = W'($urandom);
         opcode   = (c == repulso) ? matriz_pkg::SOMA : 3'($urandom_range(0, 7));
         start    = (c == repulso) || ($urandom_range(0, 3) == 0);
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      failures++;
      $display("FAIL timeout_done actual=no_done required=done_within_%0d", NN + 10);
   endtask

   // Monitor: busy run length gives latency; done pops the scoreboard.
   initial begin
      int        busy_cnt;
      esperado_t e;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            if (busy) busy_cnt++;
            else busy_cnt = 0;
            if (done) begin
               if (fila.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL done_unexpected actual=done required=no_done");
               end else begin
                  e = fila.pop_front();
                  verifica("resultado", m_resultado, e.res);
                  verifica("overflow", NNW'(overflow), NNW'(e.ovf));
                  verifica("erro", NNW'(erro), NNW'(e.err));
                  verifica("busy_cycles", NNW'(busy_cnt), NNW'(NN + 1));
                  ult_res = e.res;
                  ult_ovf = e.ovf;
                  ult_err = e.err;
               end
            end else if (!busy) begin
               verifica("hold_resultado", m_resultado, ult_res);
               verifica("hold_overflow", NNW'(overflow), NNW'(ult_ovf));
               verifica("hold_erro", NNW'(erro), NNW'(ult_err));
            end
         end
      end
   end

   task automatic verifica_zeros(input string pfx);
      verifica({pfx, "_resultado"}, m_resultado, '0);
      verifica({pfx, "_busy"}, NNW'(busy), '0);
      verifica({pfx, "_done"}, NNW'(done), '0);
      verifica({pfx, "_overflow"}, NNW'(overflow), '0);
      verifica({pfx, "_erro"}, NNW'(erro), '0);
   endtask

   initial begin
      logic [NNW-1:0] va, vb;
      logic [W-1:0]   t;

      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      verifica_zeros("reset");
      #2 reset = 1'b1;
      mon_on = 1'b1;

      // negate A[j]=j+1
      for (int j = 0; j < NN; j++) begin t = W'(j + 1); va[j*W +: W] = t; end
      @(negedge clk);
      lancar(matriz_pkg::OPOSTA, '0, va, vet_rand());
      aguardar(0);

      // negate -128 wraps; accepted in the cycle right after DONE
      for (int j = 0; j < NN; j++) begin t = 8'd1; va[j*W +: W] = t; end
      va[W-1:0] = 8'h80;
      @(negedge clk);
      lancar(matriz_pkg::OPOSTA, '0, va, vet_rand());
      aguardar(0);

      // transpose A[j]=j
      for (int j = 0; j < NN; j++) begin t = W'(j); va[j*W +: W] = t; end
      @(negedge clk);
      lancar(matriz_pkg::TRANSPOSTA, '0, va, vet_rand());
      aguardar(0);

      // scalar -3 with a SOMA start pulse at cycle 10
      @(negedge clk);
      lancar(matriz_pkg::ESCALAR, 8'hFD, va, vet_rand());
      aguardar(10);

      // 100+100 wraps to -56 everywhere, then unsupported opcode
      for (int j = 0; j < NN; j++) begin t = 8'd100; va[j*W +: W] = t; end
      vb = va;
      @(negedge clk);
      lancar(matriz_pkg::SOMA, '0, va, vb);
      aguardar(0);
      @(negedge clk);
      lancar(3'b110, W'($urandom), vet_rand(), vet_rand());
      aguardar(0);

      // reset at EXEC cycle 12
      @(negedge clk);
      lancar(matriz_pkg::SUB, '0, vet_rand(), vet_rand());
      repeat (11) @(negedge clk);
      #2 reset = 1'b0;
      fila.delete();
      ult_res = '0;
      ult_ovf = 1'b0;
      ult_err = 1'b0;
      #1 verifica_zeros("reset_mid_exec");
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      lancar(matriz_pkg::SUB, '0, vet_rand(), vet_rand());
      aguardar(0);

      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         lancar(3'($urandom_range(0, 7)), W'($urandom), vet_rand(), vet_rand());
         aguardar(0);
      end

      repeat (3) @(negedge clk);
      verifica("scoreboard_empty", NNW'(fila.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/controle_matriz.md
CONTROLE_MATRIZ -- requirements
Module: controle_matriz

Interface
REQ-001 The module SHALL have parameter N, default 5, meaning the matrix dimension (N x N elements).
REQ-002 The module SHALL have parameter W, default 8, meaning the signed element width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates happen on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 Port opcode, input, 3 bits: operation select, captured on accepted start.
REQ-007 Port escalar, input, W bits, signed: scalar operand, captured on accepted start.
REQ-008 Port matriz_A, input, N*N*W bits: operand A; element j occupies bits [j*W +: W], with j = row*N + col.
REQ-009 Port matriz_B, input, N*N*W bits: operand B, packed the same way as matriz_A.
REQ-010 Port m_resultado, output, N*N*W bits: result matrix, packed the same way.
REQ-011 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 Port done, output, 1 bit: one-cycle pulse indicating m_resultado is complete.
REQ-013 Port overflow, output, 1 bit: sticky per operation; set if any element result wrapped.
REQ-014 Port erro, output, 1 bit: set if the captured opcode is unsupported.

Function
REQ-015 The state machine SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-016 In IDLE with start=1 on a clock edge, the block SHALL capture opcode, escalar, matriz_A and matriz_B into internal registers, clear overflow and erro, set index idx=0, and move to EXEC.
REQ-017 In EXEC, each cycle SHALL compute exactly one element idx using the shared element ALU, write it to result bits [idx*W +: W], and increment idx.
REQ-018 The transition EXEC->DONE SHALL occur on the edge that writes idx = N*N-1, giving 25 EXEC cycles for N=5.
REQ-019 DONE SHALL last exactly one cycle with done=1, then move to IDLE.
REQ-020 Latency: done SHALL be high during cycle N*N+1 after the start edge, i.e. cycle 26 for N=5.
REQ-021 Opcode 000 (SOMA) SHALL compute A[idx] + B[idx].
REQ-022 Opcode 001 (SUB) SHALL compute A[idx] - B[idx].
REQ-023 Opcode 010 (OPOSTA) SHALL compute -A[idx].
REQ-024 Opcode 011 (TRANSPOSTA) SHALL compute A[col*N+row], where idx = row*N + col.
REQ-025 Opcode 100 (ESCALAR) SHALL compute escalar * A[idx].
REQ-026 Arithmetic SHALL be two's complement, computed at full width and truncated to W bits.
REQ-027 overflow SHALL be set if the full-width result lies outside [-2^(W-1), 2^(W-1)-1]; for example, -(-128) yields -128 with overflow=1.
REQ-028 Opcodes 101-111 SHALL set erro=1 and write zero elements; the block SHALL still traverse EXEC with the normal latency.
REQ-029 start SHALL be ignored while busy=1 (EXEC or DONE); no capture occurs and the sequence is unaffected.
REQ-030 Input changes after capture SHALL NOT affect the running operation.
REQ-031 m_resultado, overflow and erro SHALL hold their values from DONE until the next accepted start.
REQ-032 A start asserted in the cycle immediately after DONE (state IDLE) SHALL be accepted.

Reset
REQ-033 Asserting reset low, at any time including mid-EXEC, SHALL immediately force state IDLE, idx=0, m_resultado=0, busy=0, done=0, overflow=0, erro=0, and clear all captured operand registers.
REQ-034 After reset deasserts, the first accepted start SHALL behave identically to one issued after a normal operation.

Structure
REQ-035 A shared package matriz_pkg SHALL define N, W, the opcode constants SOMA/SUB/OPOSTA/TRANSPOSTA/ESCALAR, and the state enumeration.
REQ-036 The per-element arithmetic SHALL be a combinational sub-module elemento_ula with inputs opcode, a, b and escalar, and outputs resultado (W bits), ovf and invalido.
REQ-037 controle_matriz SHALL contain one instance of elemento_ula; the index mapping and transpose addressing SHALL remain in the controller.

Verification
REQ-038 Reset, then OPOSTA with A[j]=j+1 -> done at cycle 26, busy high for cycles 1-26, m_resultado[j]=-(j+1), overflow=0.
REQ-039 OPOSTA with A[0]=-128 and the rest 1 -> element 0 = -128, overflow=1; remaining elements -1.
REQ-040 TRANSPOSTA with A[j]=j -> m_resultado[r*5+c] = c*5+r, so element 1 = 5 and element 5 = 1.
REQ-041 ESCALAR with escalar=-3 and A[j]=j; start re-pulsed at cycle 10 with opcode SOMA -> re-pulse ignored; element 24 = -72, elements with j>=43... none, so overflow=0.
REQ-042 SOMA with all A=100, all B=100 -> every element = -56, overflow=1; then opcode 110 -> erro=1, result all zero, done at cycle 26.
REQ-043 Reset asserted at EXEC cycle 12 -> all outputs are zero immediately; a new start after release completes normally in 26 cycles.
